mdu_issue_ctrl: RTL
===================

# mdu_issue_ctrl

Issue and stall controller that sits directly upstream of the multiply/divide unit in the E stage. It turns the E-stage MDU opcode into a one-cycle `start` pulse and a gated opcode for the MDU. It mirrors the MDU latency with its own countdown. It raises the pipeline stall whenever the instruction in D needs the MDU while an operation is issuing or in flight.

## Interface
Parameters:
- `MULT_LAT`, default 5: cycles Busy stays high after a MULT/MULTU issue.
- `DIV_LAT`, default 10: cycles Busy stays high after a DIV/DIVU issue.

Ports:
- `clk` in, 1: the single clock; all state updates on its rising edge.
- `reset` in, 1: asynchronous, active-low reset (asserted when 0).
- `e_valid` in, 1: the E-stage slot holds a real, non-flushed instruction.
- `e_mdu_op` in, 4: MDU opcode of the E-stage instruction.
- `d_mdu_op` in, 4: MDU opcode of the D-stage instruction.
- `mdu_busy` in, 1: Busy output of the MDU.
- `start` out, 1: one-cycle issue pulse to the MDU.
- `mdu_op` out, 4: opcode forwarded to the MDU; MDU_NONE unless `e_valid`.
- `stall` out, 1: freezes F/D and inserts a bubble into E.
- `busy_shadow` out, 1: internal countdown is non-zero.
- `err` out, 1: sticky latency-mismatch flag; present only with MDU_ISSUE_CHECK_EN.

## Operation
- Opcode classes:
  - long ops: MULT, MULTU, DIV, DIVU.
  - access ops: MFHI, MFLO, MTHI, MTLO.
  - any other code, including MDU_NONE, is a non-MDU instruction.
- `mdu_op` = `e_valid` ? `e_mdu_op` : MDU_NONE (combinational).
- FSM states:
  - IDLE: `cnt`=0. If `e_valid` and `e_mdu_op` is a long op, `start`=1 combinationally. At the edge, load `cnt` with MULT_LAT or DIV_LAT and go to RUN.
  - RUN: `cnt` decrements each edge. At the edge where `cnt`=1, go to IDLE; the MDU commits HI/LO at that same edge.
- `start` is only ever asserted in IDLE. A long op cannot reach E during RUN because `stall` blocks it.
- `stall` = `reset` && (`d_mdu_op` is a long or access op) && (`start` || state==RUN).
- Non-MDU instructions in D never stall, whatever the state.
- Access ops in E issue no `start`; they pass through on `mdu_op` only.
- `busy_shadow` = (state==RUN).
- Reset, including mid-operation: state goes to IDLE, `cnt` to 0, `err` to 0, and `start`, `stall`, `busy_shadow` drop to 0 immediately, without waiting for a clock edge.
- `e_valid` falling in the same cycle as a long op (flush): no `start`, no state change.

## Timing
- Output values during reset: `start`=0, `stall`=0, `busy_shadow`=0, `err`=0, `mdu_op`=MDU_NONE if `e_valid`=0.
- `start` and `stall` are combinational from the current state and inputs; there is no added latency.
- MULT/MULTU followed by an MDU op in D: `stall` is high for 1 + MULT_LAT = 6 consecutive cycles. The D op enters E on the next cycle and sees the updated HI/LO.
- DIV/DIVU followed by an MDU op in D: `stall` is high for 1 + DIV_LAT = 11 cycles.
- Back-to-back long ops: the second issues on the first cycle the first is back in IDLE (zero-gap reissue).
- `mdu_busy` is expected to equal `busy_shadow` every cycle, since both rise one edge after `start`.

## Configuration
- MDU_ISSUE_CHECK_EN defined:
  - `err` port exists.
  - `err` is set at any edge where `mdu_busy` != `busy_shadow` and stays set until reset.
- Not defined:
  - `err` port is absent and no compare logic is built.
  - All other behaviour is identical.

## Structure
- Shared package/header `macro.v` holds the opcode constants: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
- It also holds the FSM state encodings IDLE=0, RUN=1.
- One natural sub-module, `mdu_op_class`: combinational decode of a 4-bit opcode into `is_long`, `is_access`, `is_div`. It is instantiated twice, once for E and once for D.

## Test plan
- E=MULT with `e_valid`=1 in IDLE, D=MFHI: `start`=1 for exactly 1 cycle; `stall`=1 for 6 cycles; MFHI enters E on cycle 7 with `stall`=0.
- E=DIV, D=MTLO: `stall`=1 for 11 cycles; `busy_shadow`=1 for cycles 2–11.
- E=MULTU, D carrying ADD (non-MDU) during RUN: `stall`=0 throughout; `cnt` still counts 5→0.
- E=DIV with `e_valid`=0: `start`=0, `mdu_op`=MDU_NONE, state stays IDLE.
- `reset`=0 asserted at `cnt`=3 of a DIV: `stall`, `busy_shadow` and `start` go to 0 before the next edge; after release, a new MULT issues normally.
- With MDU_ISSUE_CHECK_EN, force `mdu_busy`=0 during RUN: `err` goes to 1 at the next edge and stays 1 until reset.

Source files
------------

// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared constants for the MDU issue controller: opcode codes and FSM states.
package mdu_issue_ctrl_pkg;

    localparam logic [3:0] MDU_NONE = 4'd0;
    localparam logic [3:0] MULT     = 4'd1;
    localparam logic [3:0] MULTU    = 4'd2;
    localparam logic [3:0] DIV      = 4'd3;
    localparam logic [3:0] DIVU     = 4'd4;
    localparam logic [3:0] MFHI     = 4'd5;
    localparam logic [3:0] MFLO     = 4'd6;
    localparam logic [3:0] MTHI     = 4'd7;
    localparam logic [3:0] MTLO     = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mdu_op_class.sv
// Combinational decode of an MDU opcode into its issue classes.
module mdu_op_class
    import mdu_issue_ctrl_pkg::*;
(
    input  logic [3:0] op,
    output logic       is_long,
    output logic       is_access,
    output logic       is_div
);

    // Long ops occupy the MDU; access ops only touch HI/LO.
    always_comb begin
        is_long   = 1'b0;
        is_access = 1'b0;
        is_div    = 1'b0;
        case (op)
            MULT, MULTU: is_long = 1'b1;
            DIV, DIVU: begin
                is_long = 1'b1;
                is_div  = 1'b1;
            end
            MFHI, MFLO, MTHI, MTLO: is_access = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// MDU issue/stall controller.
// Optional latency cross-check against the MDU Busy output: MDU_ISSUE_CHECK_EN
// (adds the sticky err port).
//
// state | meaning
// IDLE  | no operation in flight; a long op in E issues start
// RUN   | countdown mirrors MDU latency; D-stage MDU ops stall
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_valid,
    input  logic [3:0] e_mdu_op,
    input  logic [3:0] d_mdu_op,
    input  logic       mdu_busy,
    output logic       start,
    output logic [3:0] mdu_op,
    output logic       stall,
`ifdef MDU_ISSUE_CHECK_EN
    output logic       busy_shadow,
    output logic       err
`else
    output logic       busy_shadow
`endif
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               e_is_long, e_is_access, e_is_div;
    logic               d_is_long, d_is_access, d_is_div;
    logic               d_needs_mdu;

    mdu_op_class u_e_class (
        .op        (e_mdu_op),
        .is_long   (e_is_long),
        .is_access (e_is_access),
        .is_div    (e_is_div)
    );

    mdu_op_class u_d_class (
        .op        (d_mdu_op),
        .is_long   (d_is_long),
        .is_access (d_is_access),
        .is_div    (d_is_div)
    );

    // Access ops in E and divide-ness in D do not affect issue or stall.
    logic unused_class;
    assign unused_class = e_is_access ^ d_is_div;

    assign d_needs_mdu = d_is_long | d_is_access;
    assign mdu_op      = e_valid ? e_mdu_op : MDU_NONE;
    assign busy_shadow = (state_q == RUN);
    assign stall       = reset && d_needs_mdu && (start || state_q == RUN);

    // Next state, countdown and issue pulse; start is gated by reset so it drops
    // immediately when reset asserts even with a long op sitting in E.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (reset && e_valid && e_is_long) begin
                    start   = 1'b1;
                    state_d = RUN;
                    cnt_d   = e_is_div ? DIV_CNT : MULT_CNT;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and countdown registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MDU_ISSUE_CHECK_EN
    logic err_q;

    // Sticky flag: MDU Busy disagreed with our shadow of it at some edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (mdu_busy != busy_shadow) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_busy;
    assign unused_busy = mdu_busy;
`endif

endmodule
